fma_normalizer: RTL

- Post-addition normalizer for the FMA datapath; sits downstream of the aligner and the 3:2/CPA stage.
- Takes the wide unnormalized magnitude, its exponent, sign and sticky bit. Iteratively left-shifts the magnitude until its MSB is 1 or the exponent reaches the denormal floor.
- Emits a (PARM_MANT+1)-bit mantissa plus guard/round/sticky bits for the rounder.
- Uses a valid/ready handshake on both sides; multi-cycle with bounded latency.

---
 rtl/fma_pkg.sv | 17 +
 rtl/fma_sticky_rshift.sv | 33 +++
 rtl/fma_normalizer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fma_pkg.sv
// Shared constants and FSM encoding for the FMA post-addition normalizer.
// Everything that the top, the shifter and the bench must agree on lives here.
package fma_pkg;

    localparam int PARM_EXP  = 8;
    localparam int PARM_MANT = 23;
    localparam int PARM_STEP = 8;
    localparam int PARM_BIAS = (1 << (PARM_EXP - 1)) - 1;
    localparam int W         = 3 * PARM_MANT + 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/fma_sticky_rshift.sv
// Combinational right shifter with a saturating shift amount.
// Also returns the OR of every bit pushed out past the LSB.
module fma_sticky_rshift
    import fma_pkg::*;
#(
    parameter int DW = W,
    parameter int AW = PARM_EXP + 3
) (
    input  logic [DW-1:0] data_i,
    input  logic [AW-1:0] amt_i,
    output logic [DW-1:0] data_o,
    output logic          sticky_o
);

    localparam int SW = $clog2(DW + 1);

    logic [SW-1:0] amt_cap;
    logic [DW-1:0] lost_mask;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        amt_cap = SW'(DW);
        if (int'(amt_i) < DW) begin
            amt_cap = SW'(amt_i);
        end
    end

    // A full-width shift empties the mask's complement, so every input bit counts as lost.
    assign lost_mask = ~({DW{1'b1}} << amt_cap);
    assign data_o    = data_i >> amt_cap;
    assign sticky_o  = |(data_i & lost_mask);

endmodule

// File: rtl/fma_normalizer.sv
// Iterative post-addition normalizer: coarse/fine left shifts until the MSB is set
// or the exponent hits the denormal floor, then hands mantissa + G/R/S to the rounder.
module fma_normalizer
    import fma_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    In_valid_i,
    output logic                    In_ready_o,
    input  logic                    Sign_i,
    input  logic [PARM_EXP+1:0]     Exp_i,
    input  logic [W-1:0]            Mant_i,
    input  logic                    Sticky_i,
    output logic                    Out_valid_o,
    input  logic                    Out_ready_i,
    output logic                    Sign_o,
    output logic [PARM_EXP+1:0]     Exp_o,
    output logic [PARM_MANT:0]      Mant_o,
    output logic                    Guard_o,
    output logic                    Round_o,
    output logic                    Sticky_o,
    output logic                    Zero_o,
    output logic                    Ovf_o
);

    localparam int EW = PARM_EXP + 2;
    localparam int MW = PARM_MANT + 1;

    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_STEP = EW'(PARM_STEP);
    localparam logic signed [EW-1:0] EXP_OVF  = EW'((1 << PARM_EXP) - 1);

    fsm_state_e             state_q;
    logic                   sign_q;
    logic signed [EW-1:0]   exp_q;
    logic [W-1:0]           mant_q;
    logic                   sticky_q;

    logic [EW:0]            rs_amt;
    logic [W-1:0]           rs_mant;
    logic                   rs_sticky;
    logic                   exp_in_le0;
    logic                   msb_set;
    logic                   top_zero;
    logic                   done;

    // Only meaningful when Exp_i <= 0, where 1 - Exp_i is positive and fits in EW+1 bits.
    assign rs_amt     = (EW+1)'(1) - {Exp_i[EW-1], Exp_i};
    assign exp_in_le0 = ($signed(Exp_i) <= 0);

    fma_sticky_rshift #(
        .DW (W),
        .AW (EW + 1)
    ) u_rshift (
        .data_i   (Mant_i),
        .amt_i    (rs_amt),
        .data_o   (rs_mant),
        .sticky_o (rs_sticky)
    );

    assign msb_set  = mant_q[W-1];
    assign top_zero = ~|mant_q[W-1 -: PARM_STEP];

    // NOTE: state is updated with non-blocking assignments only, so every branch reads pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (In_valid_i) begin
                        sign_q <= Sign_i;
                        if (Mant_i == '0) begin
                            mant_q   <= '0;
                            exp_q    <= '0;
                            sticky_q <= Sticky_i;
                            state_q  <= DONE;
                        end else if (exp_in_le0) begin
                            mant_q   <= rs_mant;
                            exp_q    <= EXP_ONE;
                            sticky_q <= Sticky_i | rs_sticky;
                            state_q  <= SHIFT;
                        end else begin
                            mant_q   <= Mant_i;
                            exp_q    <= $signed(Exp_i);
                            sticky_q <= Sticky_i;
                            state_q  <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    if (msb_set) begin
                        state_q <= DONE;
                    end else if (top_zero && (exp_q > EXP_STEP)) begin
                        mant_q <= mant_q << PARM_STEP;
                        exp_q  <= exp_q - EXP_STEP;
                    end else if (exp_q > EXP_ONE) begin
                        mant_q <= mant_q << 1;
                        exp_q  <= exp_q - EXP_ONE;
                    end else begin
                        // Exponent floor reached with the MSB still clear: denormal result.
                        exp_q   <= '0;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    if (Out_ready_i) begin
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign done        = (state_q == DONE);
    assign In_ready_o  = (state_q == IDLE);
    assign Out_valid_o = done;

    // Result fields are forced to zero outside DONE so nothing stale leaks downstream.
    assign Sign_o   = done & sign_q;
    assign Exp_o    = done ? exp_q : '0;
    assign Mant_o   = done ? mant_q[W-1 -: MW] : '0;
    assign Guard_o  = done & mant_q[W-MW-1];
    assign Round_o  = done & mant_q[W-MW-2];
    assign Sticky_o = done & ((|mant_q[W-MW-3:0]) | sticky_q);
    assign Zero_o   = done & (mant_q == '0) & ~sticky_q;
    assign Ovf_o    = done & (exp_q >= EXP_OVF);

endmodule
